// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and helpers for the memory responder.
//   - state_e   : responder FSM states (IDLE / WAIT / RESP)
//   - addr_err  : flags a request that is misaligned or beyond the RAM
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte address is zero-extended to 32 bits by the caller so one function
  // serves any ADDR_WIDTH up to 32. Bit 0 set means the access straddles a
  // word; the remaining bits form the word index.
  function automatic logic addr_err(input logic [31:0] byte_addr,
                                    input int unsigned depth_words);
    return byte_addr[0] | ((byte_addr >> 1) >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
//   Single-port synchronous RAM, DEPTH_WORDS x WIDTH, registered read data.
//   Ports:
//     i_clk    : clock
//     i_we     : write enable, writes i_wdata to word i_idx
//     i_re     : read enable, loads word i_idx into o_rdata
//     i_idx    : word index
//     i_wdata  : write data
//     o_rdata  : read data, holds its value when i_re is low
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int WIDTH       = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage array and its read register carry no reset so they map
  // onto a RAM macro; callers must never expose rdata before a read fills it.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_idx] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem[i_idx];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU memory port. Accepts one request at a
//   time, waits WAIT_CYCLES cycles, performs the word access on the internal
//   RAM, then presents the response until the requester takes it.
//   Ports:
//     i_clk, i_reset_n          : clock, asynchronous active-low reset
//     i_req_valid / o_req_ready : request handshake (ready only in IDLE)
//     i_req_write               : 1 = write, 0 = read
//     i_req_addr                : byte address (word aligned when legal)
//     i_req_wdata               : write data
//     o_rsp_valid / i_rsp_ready : response handshake
//     o_rsp_rdata               : read data, 0 for writes and errors
//     o_rsp_err                 : misaligned or out-of-range request
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0]      i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  err_q, err_d;
  // Set when the last access was a good read, so the RAM read register is
  // the response data; otherwise the response data is forced to zero.
  logic                  rd_sel_q, rd_sel_d;

  logic                  req_fire;
  logic                  access;
  logic                  acc_write;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [WIDTH-1:0]      acc_wdata;
  logic                  acc_err;
  logic                  mem_we;
  logic                  mem_re;
  logic [IDX_W-1:0]      mem_idx;
  logic [WIDTH-1:0]      mem_rdata;

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign req_fire    = i_req_valid & o_req_ready;

  // With no wait states the access happens on the acceptance edge, so it must
  // use the live request rather than the latched copy.
  assign acc_write = (WAIT_CYCLES == 0) ? i_req_write : write_q;
  assign acc_addr  = (WAIT_CYCLES == 0) ? i_req_addr  : addr_q;
  assign acc_wdata = (WAIT_CYCLES == 0) ? i_req_wdata : wdata_q;
  assign acc_err   = addr_err(32'(acc_addr), DEPTH_WORDS);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rd_sel_d = rd_sel_q;
    access   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          cnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (access) begin
      err_d    = acc_err;
      rd_sel_d = ~acc_write & ~acc_err;
    end
  end

  // Errors never touch the RAM; reads of the RAM only on a good read so the
  // read register stays stable through RESP and afterwards.
  assign mem_we  = access &  acc_write & ~acc_err;
  assign mem_re  = access & ~acc_write & ~acc_err;
  assign mem_idx = acc_addr[IDX_W:1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
      if (req_fire) begin
        write_q <= i_req_write;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
      end
    end
  end

  mem_array #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem_array (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_re    (mem_re),
    .i_idx   (mem_idx),
    .i_wdata (acc_wdata),
    .o_rdata (mem_rdata)
  );

  assign o_rsp_rdata = rd_sel_q ? mem_rdata : '0;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder: one instance with WAIT_CYCLES=2 and one
//   with WAIT_CYCLES=0. Expected responses come from a small RAM model and are
//   queued when a request is driven, then popped when the response appears.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk;
  logic        i_reset_n;

  // WAIT_CYCLES = 2 instance
  logic        req_valid, req_write, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;

  // WAIT_CYCLES = 0 instance
  logic        z_req_valid, z_req_write, z_rsp_ready;
  logic [15:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [15:0] z_rsp_rdata;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_w2 [256];
  logic [15:0] model_w0 [256];
  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  int          acc_cyc    = 0;

  mem_responder #(
    .WIDTH(16), .ADDR_WIDTH(16), .DEPTH_WORDS(256), .WAIT_CYCLES(2)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  mem_responder #(
    .WIDTH(16), .ADDR_WIDTH(16), .DEPTH_WORDS(256), .WAIT_CYCLES(0)
  ) dut_w0 (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (z_req_valid),
    .o_req_ready (z_req_ready),
    .i_req_write (z_req_write),
    .i_req_addr  (z_req_addr),
    .i_req_wdata (z_req_wdata),
    .o_rsp_valid (z_rsp_valid),
    .i_rsp_ready (z_rsp_ready),
    .o_rsp_rdata (z_rsp_rdata),
    .o_rsp_err   (z_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accessors that select one of the two instances.
  function automatic logic get_ready(input bit sel);
    return sel ? z_req_ready : req_ready;
  endfunction
  function automatic logic get_valid(input bit sel);
    return sel ? z_rsp_valid : rsp_valid;
  endfunction
  function automatic logic [15:0] get_rdata(input bit sel);
    return sel ? z_rsp_rdata : rsp_rdata;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? z_rsp_err : rsp_err;
  endfunction

  task automatic drive_req(input bit sel, input logic v, input logic wr,
                           input logic [15:0] a, input logic [15:0] d);
    if (sel) begin
      z_req_valid = v; z_req_write = wr; z_req_addr = a; z_req_wdata = d;
    end else begin
      req_valid = v; req_write = wr; req_addr = a; req_wdata = d;
    end
  endtask

  task automatic set_rsp_ready(input bit sel, input logic r);
    if (sel) z_rsp_ready = r;
    else     rsp_ready   = r;
  endtask

  // One transaction, entered and left on a falling edge with the DUT idle.
  // stall > 0 holds i_rsp_ready low for that many cycles of RESP while a
  // competing write is offered on the request channel.
  task automatic xact(input bit sel, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wd, input int stall);
    exp_t        e;
    exp_t        got;
    int          k;
    int          idx;
    int          lat;
    idx     = int'(addr >> 1);
    e.err   = addr[0] || (idx >= 256);
    e.rdata = 16'h0000;
    if (!wr && !e.err) e.rdata = sel ? model_w0[idx] : model_w2[idx];
    if (wr && !e.err) begin
      if (sel) model_w0[idx] = wd;
      else     model_w2[idx] = wd;
    end
    sb.push_back(e);
    lat = sel ? 1 : 3;

    check("req_ready_idle", 32'(get_ready(sel)), 32'd1);
    drive_req(sel, 1'b1, wr, addr, wd);
    set_rsp_ready(sel, stall == 0);
    acc_cyc = cyc;

    @(negedge clk);
    k = 1;
    // Scramble request inputs after acceptance; they must be ignored.
    drive_req(sel, 1'b0, ~wr, ~addr, 16'($urandom));
    while (!get_valid(sel) && k < 20) begin
      check("req_ready_wait", 32'(get_ready(sel)), 32'd0);
      @(negedge clk);
      k++;
    end
    check("rsp_latency", 32'(k), 32'(lat));
    check("req_ready_resp", 32'(get_ready(sel)), 32'd0);
    got = sb.pop_front();
    check("rsp_rdata", 32'(get_rdata(sel)), 32'(got.rdata));
    check("rsp_err", 32'(get_err(sel)), 32'(got.err));

    for (int s = 0; s < stall; s++) begin
      drive_req(sel, 1'b1, 1'b1, addr, 16'hDEAD);
      @(negedge clk);
      check("stall_valid", 32'(get_valid(sel)), 32'd1);
      check("stall_rdata", 32'(get_rdata(sel)), 32'(got.rdata));
      check("stall_ready", 32'(get_ready(sel)), 32'd0);
    end
    if (stall > 0) begin
      drive_req(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_rsp_ready(sel, 1'b1);
    end

    @(negedge clk);
    check("done_valid", 32'(get_valid(sel)), 32'd0);
    check("done_ready", 32'(get_ready(sel)), 32'd1);
    check("done_rdata_held", 32'(get_rdata(sel)), 32'(got.rdata));
  endtask

  initial begin
    int a0;
    i_reset_n = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rsp_ready   = 1'b0;
    z_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0000);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_w0_ready",  32'(z_req_ready), 32'd1);
    i_reset_n = 1'b1;
    @(negedge clk);

    // Basic write then read-after-write
    xact(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0);
    xact(1'b0, 1'b0, 16'h0010, 16'h0000, 0);

    // Misaligned read
    xact(1'b0, 1'b0, 16'h0011, 16'h0000, 0);

    // Backpressure: competing write of 0xDEAD must not be taken
    xact(1'b0, 1'b0, 16'h0010, 16'h0000, 5);
    check("bp_rdata_literal", 32'(rsp_rdata), 32'h0000BEEF);
    xact(1'b0, 1'b0, 16'h0010, 16'h0000, 0);

    // Back-to-back writes and reads with i_rsp_ready held high
    xact(1'b0, 1'b1, 16'h0000, 16'h1111, 0);
    a0 = acc_cyc;
    xact(1'b0, 1'b1, 16'h0002, 16'h2222, 0);
    check("b2b_spacing_1", 32'(acc_cyc - a0), 32'd4);
    a0 = acc_cyc;
    xact(1'b0, 1'b1, 16'h0004, 16'h3333, 0);
    check("b2b_spacing_2", 32'(acc_cyc - a0), 32'd4);
    xact(1'b0, 1'b0, 16'h0000, 16'h0000, 0);
    xact(1'b0, 1'b0, 16'h0002, 16'h0000, 0);
    xact(1'b0, 1'b0, 16'h0004, 16'h0000, 0);

    // Out-of-range write (index 256) leaves word 0 alone
    xact(1'b0, 1'b1, 16'h0200, 16'hCAFE, 0);
    xact(1'b0, 1'b0, 16'h0000, 16'h0000, 0);

    // Reset during WAIT drops the pending write
    xact(1'b0, 1'b1, 16'h0020, 16'h5555, 0);
    drive_req(1'b0, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
    rsp_ready = 1'b1;
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    i_reset_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", 32'(rsp_rdata), 32'h0000);
    check("midrst_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 1'b0, 16'h0020, 16'h0000, 0);
    check("midrst_keep_5555", 32'(rsp_rdata), 32'h00005555);

    // Zero wait-state instance
    xact(1'b1, 1'b1, 16'h0008, 16'h1234, 0);
    xact(1'b1, 1'b0, 16'h0008, 16'h0000, 0);
    xact(1'b1, 1'b0, 16'h0009, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
